// File: rtl/vr16_pkg.sv
// Shared definitions for the VR16 control-flow front end: op encodings,
// branch controller FSM states and default geometry.
package vr16_pkg;

  localparam int ADDR_W_DEF      = 16;
  localparam int STACK_DEPTH_DEF = 8;

  typedef enum logic [2:0] {
    OP_NOP  = 3'd0,
    OP_JMP  = 3'd1,
    OP_JZ   = 3'd2,
    OP_JNZ  = 3'd3,
    OP_CALL = 3'd4,
    OP_RET  = 3'd5
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_REDIRECT = 2'd1,
    ST_FLUSH    = 2'd2
  } state_e;

endpackage

// File: rtl/ras_stack.sv
// Return-address stack: LIFO with saturating occupancy. Pushes when full and
// pops when empty are dropped; entry contents are never reset.
module ras_stack #(
  parameter int DEPTH  = 8,
  parameter int DATA_W = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic                     pop,
  input  logic [DATA_W-1:0]        push_data,
  output logic [DATA_W-1:0]        top_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   depth
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [PTR_W:0]    depth_reg;
  logic [PTR_W:0]    depth_next;
  logic [DATA_W-1:0] entry_reg [DEPTH];
  logic [PTR_W-1:0]  top_idx;
  logic              push_ok;
  logic              pop_ok;

  assign full    = (depth_reg == (PTR_W+1)'(DEPTH));
  assign empty   = (depth_reg == '0);
  assign push_ok = push & ~full;
  assign pop_ok  = pop & ~empty & ~push_ok;
  assign depth   = depth_reg;

  // Low pointer bits minus one wrap to DEPTH-1 when the stack is full.
  assign top_idx  = depth_reg[PTR_W-1:0] - PTR_W'(1);
  assign top_data = entry_reg[top_idx];

  always_comb begin
    depth_next = depth_reg;
    if (push_ok) begin
      depth_next = depth_reg + (PTR_W+1)'(1);
    end else if (pop_ok) begin
      depth_next = depth_reg - (PTR_W+1)'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      depth_reg <= '0;
    end else begin
      depth_reg <= depth_next;
    end
  end

  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
    always_ff @(posedge clk) begin
      if (push_ok && (depth_reg[PTR_W-1:0] == PTR_W'(gi))) begin
        entry_reg[gi] <= push_data;
      end
    end
  end

endmodule

// File: rtl/branch_ctrl.sv
// Branch controller: resolves JMP/JZ/JNZ/CALL/RET in IDLE, then issues a
// one-cycle PC load strobe (REDIRECT) followed by one flush cycle.
module branch_ctrl
  import vr16_pkg::*;
#(
  parameter int STACK_DEPTH = STACK_DEPTH_DEF,
  parameter int ADDR_W      = ADDR_W_DEF
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         instr_valid,
  input  logic [2:0]                   op,
  input  logic [ADDR_W-1:0]            target,
  input  logic                         zero_flag,
  input  logic [ADDR_W-1:0]            pc_value,
  input  logic                         err_clear,
  output logic                         jump_enable,
  output logic                         return_enable,
  output logic [ADDR_W-1:0]            jump_address,
  output logic                         stall,
  output logic [$clog2(STACK_DEPTH):0] stack_depth,
  output logic                         stack_overflow,
  output logic                         stack_underflow
);

  state_e            state_reg, state_next;
  logic [ADDR_W-1:0] addr_reg, addr_next;
  logic              is_ret_reg, is_ret_next;
  logic              ovf_reg, ovf_next;
  logic              unf_reg, unf_next;

  logic              taken;
  logic              push;
  logic              pop;
  logic              ovf_set;
  logic              unf_set;
  logic              stk_full;
  logic              stk_empty;
  logic [ADDR_W-1:0] ret_addr;
  logic [ADDR_W-1:0] top_data;

  assign ret_addr = pc_value + ADDR_W'(1);

  ras_stack #(
    .DEPTH  (STACK_DEPTH),
    .DATA_W (ADDR_W)
  ) u_ras (
    .clk       (clk),
    .reset     (reset),
    .push      (push),
    .pop       (pop),
    .push_data (ret_addr),
    .top_data  (top_data),
    .full      (stk_full),
    .empty     (stk_empty),
    .depth     (stack_depth)
  );

  always_comb begin
    state_next  = state_reg;
    addr_next   = addr_reg;
    is_ret_next = is_ret_reg;
    taken       = 1'b0;
    push        = 1'b0;
    pop         = 1'b0;
    ovf_set     = 1'b0;
    unf_set     = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        if (instr_valid) begin
          case (op)
            OP_JMP: taken = 1'b1;
            OP_JZ:  taken = zero_flag;
            OP_JNZ: taken = ~zero_flag;
            OP_CALL: begin
              if (stk_full) begin
                ovf_set = 1'b1;
              end else begin
                taken = 1'b1;
                push  = 1'b1;
              end
            end
            OP_RET: begin
              if (stk_empty) begin
                unf_set = 1'b1;
              end else begin
                taken = 1'b1;
                pop   = 1'b1;
              end
            end
            default: taken = 1'b0;
          endcase
        end
        if (taken) begin
          state_next  = ST_REDIRECT;
          // RET captures the entry being popped on this same edge.
          addr_next   = pop ? top_data : target;
          is_ret_next = pop;
        end
      end
      ST_REDIRECT: state_next = ST_FLUSH;
      ST_FLUSH:    state_next = ST_IDLE;
      default:     state_next = ST_IDLE;
    endcase

    ovf_next = ovf_set ? 1'b1 : (err_clear ? 1'b0 : ovf_reg);
    unf_next = unf_set ? 1'b1 : (err_clear ? 1'b0 : unf_reg);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg  <= ST_IDLE;
      addr_reg   <= '0;
      is_ret_reg <= 1'b0;
      ovf_reg    <= 1'b0;
      unf_reg    <= 1'b0;
    end else begin
      state_reg  <= state_next;
      addr_reg   <= addr_next;
      is_ret_reg <= is_ret_next;
      ovf_reg    <= ovf_next;
      unf_reg    <= unf_next;
    end
  end

  assign jump_enable     = (state_reg == ST_REDIRECT) & ~is_ret_reg;
  assign return_enable   = (state_reg == ST_REDIRECT) & is_ret_reg;
  assign jump_address    = addr_reg;
  assign stall           = (state_reg != ST_IDLE);
  assign stack_overflow  = ovf_reg;
  assign stack_underflow = unf_reg;

endmodule

// File: tb/tb_branch_ctrl.sv
// Self-checking bench for branch_ctrl: directed scenarios plus randomized
// traffic against a queue-based reference model of the controller.
module tb_branch_ctrl;

  localparam int AW = 16;
  localparam int SD = 8;
  localparam int DW = 4;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          instr_valid = 1'b0;
  logic [2:0]    op = 3'd0;
  logic [AW-1:0] target = '0;
  logic          zero_flag = 1'b0;
  logic [AW-1:0] pc_value = '0;
  logic          err_clear = 1'b0;
  logic          jump_enable;
  logic          return_enable;
  logic [AW-1:0] jump_address;
  logic          stall;
  logic [DW-1:0] stack_depth;
  logic          stack_overflow;
  logic          stack_underflow;

  always #5 clk = ~clk;

  branch_ctrl #(.STACK_DEPTH(SD), .ADDR_W(AW)) dut (
    .clk             (clk),
    .reset           (reset),
    .instr_valid     (instr_valid),
    .op              (op),
    .target          (target),
    .zero_flag       (zero_flag),
    .pc_value        (pc_value),
    .err_clear       (err_clear),
    .jump_enable     (jump_enable),
    .return_enable   (return_enable),
    .jump_address    (jump_address),
    .stall           (stall),
    .stack_depth     (stack_depth),
    .stack_overflow  (stack_overflow),
    .stack_underflow (stack_underflow)
  );

  int checks = 0;
  int failures = 0;

  // Reference model: pending stall cycles, redirect kind/address, LIFO queue.
  logic [AW-1:0] m_stack [$];
  int            m_busy = 0;
  int            m_kind = 0;
  logic [AW-1:0] m_addr = '0;
  logic          m_ovf = 1'b0;
  logic          m_unf = 1'b0;
  logic [24:0]   exp_vec = '0;

  wire [24:0] obs_vec = {jump_enable, return_enable, stall, stack_depth,
                         stack_overflow, stack_underflow,
                         (jump_enable | return_enable) ? jump_address : 16'h0000};

  task automatic model_reset();
    m_stack.delete();
    m_busy = 0;
    m_kind = 0;
    m_ovf  = 1'b0;
    m_unf  = 1'b0;
  endtask

  // One clock: drive at negedge, advance model, sample 1 ns after posedge.
  task automatic step(input bit v, input logic [2:0] o, input logic [AW-1:0] t,
                      input logic [AW-1:0] pc, input bit zf, input bit clr);
    bit            ovs;
    bit            uns;
    bit            tk;
    int            kind;
    logic [AW-1:0] a;
    logic [AW-1:0] nxt;
    ovs = 0; uns = 0; tk = 0; kind = 0; a = '0;
    nxt = pc + 16'd1;
    @(negedge clk);
    instr_valid = v; op = o; target = t; pc_value = pc; zero_flag = zf; err_clear = clr;
    if (m_busy > 0) begin
      m_busy--;
    end else if (v) begin
      case (o)
        3'd1: begin tk = 1; kind = 1; a = t; end
        3'd2: if (zf)  begin tk = 1; kind = 1; a = t; end
        3'd3: if (!zf) begin tk = 1; kind = 1; a = t; end
        3'd4: begin
          if (m_stack.size() < SD) begin
            m_stack.push_back(nxt);
            tk = 1; kind = 1; a = t;
          end else begin
            ovs = 1;
          end
        end
        3'd5: begin
          if (m_stack.size() > 0) begin
            a = m_stack.pop_back();
            tk = 1; kind = 2;
          end else begin
            uns = 1;
          end
        end
        default: tk = 0;
      endcase
    end
    if (tk) begin
      m_busy = 2; m_kind = kind; m_addr = a;
    end
    m_ovf = ovs ? 1'b1 : (clr ? 1'b0 : m_ovf);
    m_unf = uns ? 1'b1 : (clr ? 1'b0 : m_unf);
    exp_vec = {(m_busy == 2) && (m_kind == 1), (m_busy == 2) && (m_kind == 2), m_busy > 0,
               DW'(m_stack.size()), m_ovf, m_unf, (m_busy == 2) ? m_addr : 16'h0000};
    @(posedge clk);
    #1;
    instr_valid = 1'b0;
    err_clear   = 1'b0;
    if (v) $display("txn op=%0d target=%h pc=%h zf=%0d clr=%0d -> je=%0b re=%0b addr=%h stall=%0b depth=%0d ovf=%0b unf=%0b",
                    o, t, pc, zf, clr, jump_enable, return_enable, jump_address, stall,
                    stack_depth, stack_overflow, stack_underflow);
  endtask

  task automatic test_reset();
    reset = 1'b0;
    #12;
    checks++;
    if ({jump_enable, return_enable, stall, stack_depth, stack_overflow, stack_underflow, jump_address} !== '0) begin
      failures++;
      $display("FAIL reset_state: je=%0b re=%0b stall=%0b depth=%0d ovf=%0b unf=%0b addr=%h expected all 0",
               jump_enable, return_enable, stall, stack_depth, stack_overflow, stack_underflow, jump_address);
    end
    @(negedge clk);
    reset = 1'b1;
    model_reset();
  endtask

  task automatic test_jmp();
    step(1, 3'd1, 16'h3333, 16'h0010, 0, 0);
    checks++;
    if (jump_enable !== 1'b1 || jump_address !== 16'h3333 || stall !== 1'b1) begin
      failures++;
      $display("FAIL jmp_strobe: je=%0b addr=%h stall=%0b expected je=1 addr=3333 stall=1", jump_enable, jump_address, stall);
    end
    for (int i = 0; i < 2; i++) begin
      step(0, 3'd0, 16'h0, 16'h0, 0, 0);
      checks++;
      if (obs_vec !== exp_vec || stall !== (i == 0)) begin
        failures++;
        $display("FAIL jmp_stall%0d: got %h stall=%0b expected %h", i, obs_vec, stall, exp_vec);
      end
    end
  endtask

  task automatic test_cond();
    step(1, 3'd2, 16'h0040, 16'h0020, 0, 0);
    checks++;
    if (jump_enable !== 1'b0 || stall !== 1'b0) begin
      failures++;
      $display("FAIL jz_not_taken: je=%0b stall=%0b expected je=0 stall=0", jump_enable, stall);
    end
    step(1, 3'd2, 16'h0040, 16'h0021, 1, 0);
    checks++;
    if (jump_enable !== 1'b1 || jump_address !== 16'h0040) begin
      failures++;
      $display("FAIL jz_taken: je=%0b addr=%h expected je=1 addr=0040", jump_enable, jump_address);
    end
    step(0, 3'd0, 16'h0, 16'h0, 0, 0);
    step(0, 3'd0, 16'h0, 16'h0, 0, 0);
    step(1, 3'd3, 16'h0050, 16'h0030, 0, 0);
    checks++;
    if (obs_vec !== exp_vec) begin
      failures++;
      $display("FAIL jnz_taken: got %h expected %h", obs_vec, exp_vec);
    end
    step(0, 3'd0, 16'h0, 16'h0, 0, 0);
    step(0, 3'd0, 16'h0, 16'h0, 0, 0);
  endtask

  task automatic test_call_ret();
    logic [2:0]    ops   [4] = '{3'd4, 3'd4, 3'd5, 3'd5};
    logic [AW-1:0] pcs   [4] = '{16'h0100, 16'h0201, 16'h0300, 16'h0202};
    logic [AW-1:0] tgts  [4] = '{16'h0200, 16'h0300, 16'h0000, 16'h0000};
    logic [AW-1:0] addrs [4] = '{16'h0200, 16'h0300, 16'h0202, 16'h0101};
    int            depths[4] = '{1, 2, 1, 0};
    checks++;
    if (stack_depth !== 4'd0) begin
      failures++;
      $display("FAIL call_depth_init: depth=%0d expected 0", stack_depth);
    end
    for (int i = 0; i < 4; i++) begin
      step(1, ops[i], tgts[i], pcs[i], 0, 0);
      checks++;
      if (stack_depth !== DW'(depths[i]) || jump_address !== addrs[i] ||
          jump_enable !== (ops[i] == 3'd4) || return_enable !== (ops[i] == 3'd5)) begin
        failures++;
        $display("FAIL call_ret%0d: je=%0b re=%0b addr=%h depth=%0d expected addr=%h depth=%0d",
                 i, jump_enable, return_enable, jump_address, stack_depth, addrs[i], depths[i]);
      end
      step(0, 3'd0, 16'h0, 16'h0, 0, 0);
      step(0, 3'd0, 16'h0, 16'h0, 0, 0);
    end
  endtask

  task automatic test_wrap();
    step(1, 3'd4, 16'h1000, 16'hFFFF, 0, 0);
    step(0, 3'd0, 16'h0, 16'h0, 0, 0);
    step(0, 3'd0, 16'h0, 16'h0, 0, 0);
    step(1, 3'd5, 16'h0, 16'h1000, 0, 0);
    checks++;
    if (return_enable !== 1'b1 || jump_enable !== 1'b0 || jump_address !== 16'h0000) begin
      failures++;
      $display("FAIL ret_wrap: re=%0b je=%0b addr=%h expected re=1 je=0 addr=0000", return_enable, jump_enable, jump_address);
    end
    step(0, 3'd0, 16'h0, 16'h0, 0, 0);
    step(0, 3'd0, 16'h0, 16'h0, 0, 0);
  endtask

  task automatic test_errors();
    for (int i = 0; i < 9; i++) begin
      step(1, 3'd4, 16'h0400 + 16'(i), 16'h0A00 + 16'(i), 0, 0);
      if (i < 8) begin
        step(0, 3'd0, 16'h0, 16'h0, 0, 0);
        step(0, 3'd0, 16'h0, 16'h0, 0, 0);
      end
    end
    checks++;
    if (stack_overflow !== 1'b1 || stack_depth !== 4'd8 || jump_enable !== 1'b0 || stall !== 1'b0) begin
      failures++;
      $display("FAIL overflow: ovf=%0b depth=%0d je=%0b stall=%0b expected ovf=1 depth=8 je=0 stall=0",
               stack_overflow, stack_depth, jump_enable, stall);
    end
    for (int i = 0; i < 8; i++) begin
      step(1, 3'd5, 16'h0, 16'h0, 0, 0);
      checks++;
      if (obs_vec !== exp_vec) begin
        failures++;
        $display("FAIL drain%0d: got %h expected %h", i, obs_vec, exp_vec);
      end
      step(0, 3'd0, 16'h0, 16'h0, 0, 0);
      step(0, 3'd0, 16'h0, 16'h0, 0, 0);
    end
    step(1, 3'd5, 16'h0, 16'h0, 0, 0);
    checks++;
    if (stack_underflow !== 1'b1 || return_enable !== 1'b0 || stall !== 1'b0) begin
      failures++;
      $display("FAIL underflow: unf=%0b re=%0b stall=%0b expected unf=1 re=0 stall=0", stack_underflow, return_enable, stall);
    end
    step(0, 3'd0, 16'h0, 16'h0, 0, 1);
    checks++;
    if (stack_overflow !== 1'b0 || stack_underflow !== 1'b0) begin
      failures++;
      $display("FAIL err_clear: ovf=%0b unf=%0b expected 0 0", stack_overflow, stack_underflow);
    end
    step(1, 3'd5, 16'h0, 16'h0, 0, 1);
    checks++;
    if (stack_underflow !== 1'b1) begin
      failures++;
      $display("FAIL set_wins: unf=%0b expected 1", stack_underflow);
    end
    step(0, 3'd0, 16'h0, 16'h0, 0, 1);
  endtask

  task automatic test_flush_ignore();
    step(1, 3'd1, 16'h0777, 16'h0070, 0, 0);
    step(1, 3'd4, 16'h0888, 16'h0071, 0, 0);
    checks++;
    if (stall !== 1'b1 || jump_enable !== 1'b0 || stack_depth !== 4'd0) begin
      failures++;
      $display("FAIL flush_state: stall=%0b je=%0b depth=%0d expected stall=1 je=0 depth=0", stall, jump_enable, stack_depth);
    end
    step(1, 3'd1, 16'h0999, 16'h0072, 0, 0);
    step(0, 3'd0, 16'h0, 16'h0, 0, 0);
    checks++;
    if (jump_enable !== 1'b0 || stall !== 1'b0 || stack_depth !== 4'd0) begin
      failures++;
      $display("FAIL flush_ignore: je=%0b stall=%0b depth=%0d expected 0 0 0", jump_enable, stall, stack_depth);
    end
  endtask

  task automatic test_random();
    int nbad;
    nbad = 0;
    for (int i = 0; i < 400; i++) begin
      int            r;
      logic [2:0]    o;
      r = int'($urandom_range(0, 11));
      o = (r >= 8) ? ((r >= 10) ? 3'd5 : 3'd4) : 3'(r);
      step($urandom_range(0, 3) != 0, o, 16'($urandom), 16'($urandom),
           1'($urandom_range(0, 1)), $urandom_range(0, 15) == 0);
      checks++;
      if (obs_vec !== exp_vec) begin
        failures++;
        nbad++;
        if (nbad <= 10) $display("FAIL random%0d: got %h expected %h", i, obs_vec, exp_vec);
      end
    end
  endtask

  task automatic test_reset_mid();
    step(1, 3'd4, 16'h0500, 16'h0123, 0, 0);
    step(0, 3'd0, 16'h0, 16'h0, 0, 0);
    step(0, 3'd0, 16'h0, 16'h0, 0, 0);
    step(1, 3'd1, 16'h0ABC, 16'h0200, 0, 0);
    #2;
    reset = 1'b0;
    #1;
    checks++;
    if ({jump_enable, return_enable, stall, stack_depth, stack_overflow, stack_underflow, jump_address} !== '0) begin
      failures++;
      $display("FAIL reset_mid: je=%0b re=%0b stall=%0b depth=%0d addr=%h expected all 0",
               jump_enable, return_enable, stall, stack_depth, jump_address);
    end
    reset = 1'b1;
    model_reset();
    step(1, 3'd1, 16'h1234, 16'h0300, 0, 0);
    checks++;
    if (jump_enable !== 1'b1 || jump_address !== 16'h1234) begin
      failures++;
      $display("FAIL post_reset_accept: je=%0b addr=%h expected je=1 addr=1234", jump_enable, jump_address);
    end
    step(0, 3'd0, 16'h0, 16'h0, 0, 0);
    step(0, 3'd0, 16'h0, 16'h0, 0, 0);
  endtask

  initial begin
    test_reset();
    test_jmp();
    test_cond();
    test_call_ret();
    test_wrap();
    test_errors();
    test_flush_ignore();
    test_random();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
